// File: rtl/board_step_ctrl_if.sv
// Board-control signal bundle: raw buttons and CPU halt in, CPU clock-enable,
// reset and status out. The controller uses the slave side.
interface board_step_ctrl_if;
  logic        btn_rst;
  logic        btn_step;
  logic        btn_run;
  logic        btn_view;
  logic        cpu_halt;
  logic        cpu_clk_en;
  logic        cpu_rst;
  logic        run_mode;
  logic [2:0]  view_sel;
  logic [15:0] step_count;

  modport master (
    output btn_rst, btn_step, btn_run, btn_view, cpu_halt,
    input  cpu_clk_en, cpu_rst, run_mode, view_sel, step_count
  );

  modport slave (
    input  btn_rst, btn_step, btn_run, btn_view, cpu_halt,
    output cpu_clk_en, cpu_rst, run_mode, view_sel, step_count
  );
endinterface

// File: rtl/board_step_ctrl.sv
// Front-panel controller: debounces four buttons and single-steps, free-runs,
// halts or resets a CPU through a clock-enable pulse; also cycles a display view.
module board_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int NUM_VIEWS       = 7
) (
  input  logic              clk,
  input  logic              rst,
  board_step_ctrl_if.slave  bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DVW = $clog2(RUN_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(RUN_DIV - 1);
  localparam logic [2:0]     VIEW_LAST = 3'(NUM_VIEWS - 1);

  localparam int B_RST  = 0;
  localparam int B_STEP = 1;
  localparam int B_RUN  = 2;
  localparam int B_VIEW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_RESET = 2'd3
  } state_t;

  logic [3:0]          w_btn_raw;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_db_level;
  logic [3:0]          r_evt;
  logic [3:0][DBW-1:0] r_db_cnt;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DVW-1:0] r_div;
  logic [DVW-1:0] w_div_nxt;
  logic           r_cpu_clk_en;
  logic           w_cpu_clk_en_nxt;
  logic           r_cpu_rst;
  logic           w_cpu_rst_nxt;
  logic           r_run_mode;
  logic           w_run_mode_nxt;
  logic [2:0]     r_view_sel;
  logic [2:0]     w_view_sel_nxt;
  logic [15:0]    r_step_count;
  logic [15:0]    w_step_count_nxt;
  logic           w_rst_req;

  assign w_btn_raw = {bus.btn_view, bus.btn_run, bus.btn_step, bus.btn_rst};

  // Synchronize, debounce and edge-detect every button; the event fires with the rising level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 4'b0000;
      r_sync2    <= 4'b0000;
      r_db_level <= 4'b0000;
      r_evt      <= 4'b0000;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_db_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_level[i] <= r_sync2[i];
            r_db_cnt[i]   <= '0;
            r_evt[i]      <= r_sync2[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            r_evt[i]    <= 1'b0;
          end
        end else begin
          r_db_cnt[i] <= '0;
          r_evt[i]    <= 1'b0;
        end
      end
    end
  end

  assign w_rst_req = r_db_level[B_RST] | r_evt[B_RST];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: reset outranks halt, halt outranks the run toggle, the run toggle outranks step.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_rst_req) begin
      w_state_nxt = S_RESET;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_evt[B_RUN] && !bus.cpu_halt) begin
            w_state_nxt = S_RUN;
          end else if (r_evt[B_STEP]) begin
            w_state_nxt = S_STEP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_STEP:  w_state_nxt = S_IDLE;
        S_RUN: begin
          if (bus.cpu_halt || r_evt[B_RUN]) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_RESET: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output lands in a register.
  always_comb begin
    w_div_nxt        = '0;
    w_cpu_clk_en_nxt = 1'b0;
    w_cpu_rst_nxt    = 1'b0;
    w_run_mode_nxt   = 1'b0;
    w_step_count_nxt = r_step_count;
    w_view_sel_nxt   = r_view_sel;

    if ((w_state_nxt == S_RUN) && (r_state == S_RUN)) begin
      if (r_div == DIV_LAST) begin
        w_div_nxt = '0;
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end else begin
      w_div_nxt = '0;
    end

    // A run pulse only coincides with the divider's terminal value, which is never its entry value.
    w_cpu_clk_en_nxt = (w_state_nxt == S_STEP) ||
                       ((w_state_nxt == S_RUN) && (w_div_nxt == DIV_LAST));
    w_cpu_rst_nxt    = (w_state_nxt == S_RESET);
    w_run_mode_nxt   = (w_state_nxt == S_RUN);

    if (w_state_nxt == S_RESET) begin
      w_step_count_nxt = 16'h0000;
    end else if (w_cpu_clk_en_nxt) begin
      w_step_count_nxt = r_step_count + 16'h0001;
    end else begin
      w_step_count_nxt = r_step_count;
    end

    if (r_evt[B_VIEW]) begin
      if (r_view_sel == VIEW_LAST) begin
        w_view_sel_nxt = 3'd0;
      end else begin
        w_view_sel_nxt = r_view_sel + 3'd1;
      end
    end else begin
      w_view_sel_nxt = r_view_sel;
    end
  end

  // Output and divider registers; the CPU is held in reset while the board reset is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div        <= '0;
      r_cpu_clk_en <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_run_mode   <= 1'b0;
      r_step_count <= 16'h0000;
      r_view_sel   <= 3'd0;
    end else begin
      r_div        <= w_div_nxt;
      r_cpu_clk_en <= w_cpu_clk_en_nxt;
      r_cpu_rst    <= w_cpu_rst_nxt;
      r_run_mode   <= w_run_mode_nxt;
      r_step_count <= w_step_count_nxt;
      r_view_sel   <= w_view_sel_nxt;
    end
  end

  assign bus.cpu_clk_en = r_cpu_clk_en;
  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.run_mode   = r_run_mode;
  assign bus.view_sel   = r_view_sel;
  assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_board_step_ctrl.sv
// Randomized bench for board_step_ctrl: expected step counts and view indices
// are queued when buttons are pressed and popped by a monitor on each DUT output event.
module tb_board_step_ctrl;

  localparam int D  = 4;
  localparam int RD = 3;
  localparam int NV = 7;
  // A raw edge driven in cycle s becomes a visible button event in cycle s+LAT.
  localparam int LAT = D + 2;

  localparam int B_RST  = 0;
  localparam int B_STEP = 1;
  localparam int B_RUN  = 2;
  localparam int B_VIEW = 3;

  logic clk = 1'b0;
  logic rst;

  board_step_ctrl_if ifc ();

  board_step_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .RUN_DIV         (RD),
    .NUM_VIEWS       (NV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt[$];
  logic [2:0]  exp_view[$];
  int          model_count = 0;
  int          model_view  = 0;
  logic        mon_en      = 1'b0;
  logic        prev_en     = 1'b0;
  logic [2:0]  prev_view   = 3'd0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_RST:   ifc.btn_rst  = v;
      B_STEP:  ifc.btn_step = v;
      B_RUN:   ifc.btn_run  = v;
      default: ifc.btn_view = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    tick(hold);
    set_btn(b, 1'b0);
    tick(D + 4);
  endtask

  task automatic expect_pulses(input int n);
    for (int j = 0; j < n; j++) begin
      model_count = (model_count + 1) % 65536;
      exp_cnt.push_back(16'(model_count));
    end
  endtask

  task automatic expect_view();
    model_view = (model_view + 1) % NV;
    exp_view.push_back(3'(model_view));
  endtask

  // Monitor: every clock-enable pulse and every view change consumes one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.cpu_clk_en) begin
        check("clk_en_not_back_to_back", int'(prev_en), 0);
        if (exp_cnt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_clk_en: pulse with step_count=%0d, none expected", ifc.step_count);
        end else begin
          check("step_count_at_pulse", int'(ifc.step_count), int'(exp_cnt.pop_front()));
        end
      end
      if (ifc.view_sel != prev_view) begin
        if (exp_view.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_view_change: view_sel=%0d, none expected", ifc.view_sel);
        end else begin
          check("view_sel_sequence", int'(ifc.view_sel), int'(exp_view.pop_front()));
        end
      end
    end
    prev_en   <= ifc.cpu_clk_en;
    prev_view <= ifc.view_sel;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int k_run;
    int base;

    rst          = 1'b0;
    ifc.btn_rst  = 1'b0;
    ifc.btn_step = 1'b0;
    ifc.btn_run  = 1'b0;
    ifc.btn_view = 1'b0;
    ifc.cpu_halt = 1'b0;
    tick(3);
    check("reset_cpu_rst",    int'(ifc.cpu_rst), 1);
    check("reset_clk_en",     int'(ifc.cpu_clk_en), 0);
    check("reset_run_mode",   int'(ifc.run_mode), 0);
    check("reset_view_sel",   int'(ifc.view_sel), 0);
    check("reset_step_count", int'(ifc.step_count), 0);
    rst = 1'b1;
    tick(1);
    check("cpu_rst_after_release", int'(ifc.cpu_rst), 0);
    mon_en = 1'b1;

    // Ten-cycle press: one pulse exactly one cycle after the event.
    expect_pulses(1);
    set_btn(B_STEP, 1'b1);
    tick(LAT);
    check("step_latency_before", int'(ifc.cpu_clk_en), 0);
    tick(1);
    check("step_latency_pulse", int'(ifc.cpu_clk_en), 1);
    tick(10 - LAT - 1);
    set_btn(B_STEP, 1'b0);
    tick(D + 4);
    check("step_count_one", int'(ifc.step_count), 1);

    set_btn(B_STEP, 1'b1);
    tick(2);
    set_btn(B_STEP, 1'b0);
    tick(D + 6);
    check("glitch_ignored", int'(ifc.step_count), 1);

    // Random glitches, bounces and steps, some with halt held (halt must not block a step).
    for (int k = 0; k < 6; k++) begin
      set_btn(B_STEP, 1'b1);
      tick($urandom_range(1, D - 1));
      set_btn(B_STEP, 1'b0);
      tick(D + 4);
      ifc.cpu_halt = 1'($urandom_range(0, 1));
      expect_pulses(1);
      if ($urandom_range(0, 1) == 1) begin
        set_btn(B_STEP, 1'b1);
        tick($urandom_range(1, D - 1));
        set_btn(B_STEP, 1'b0);
        tick(1);
      end
      press(B_STEP, $urandom_range(D, D + 6));
      ifc.cpu_halt = 1'b0;
      check("step_count_after_press", int'(ifc.step_count), model_count);
    end

    // Run entered by button, stopped by button.
    base = model_count;
    set_btn(B_RUN, 1'b1);
    tick(LAT);
    check("run_mode_before_entry", int'(ifc.run_mode), 0);
    tick(1);
    check("run_mode_entry", int'(ifc.run_mode), 1);
    set_btn(B_RUN, 1'b0);
    p = $urandom_range(9, 14);
    expect_pulses((p + LAT) / RD);
    tick(8);
    check("step_count_after_9_run_cycles", int'(ifc.step_count), (base + 3) % 65536);
    tick(p - 9);
    set_btn(B_RUN, 1'b1);
    tick(LAT);
    check("run_mode_last_cycle", int'(ifc.run_mode), 1);
    tick(1);
    check("run_mode_after_stop", int'(ifc.run_mode), 0);
    set_btn(B_RUN, 1'b0);
    tick(D + 6);
    check("step_count_after_stop", int'(ifc.step_count), model_count);

    // Run stopped by halt; a run press while halted is refused.
    set_btn(B_RUN, 1'b1);
    tick(LAT + 1);
    check("run_mode_entry_2", int'(ifc.run_mode), 1);
    set_btn(B_RUN, 1'b0);
    k_run = $urandom_range(4, 12);
    expect_pulses(k_run / RD);
    tick(k_run - 1);
    ifc.cpu_halt = 1'b1;
    tick(1);
    check("halt_exit", int'(ifc.run_mode), 0);
    tick(D + 4);
    set_btn(B_RUN, 1'b1);
    tick(LAT + 3);
    check("run_blocked_by_halt", int'(ifc.run_mode), 0);
    set_btn(B_RUN, 1'b0);
    tick(D + 4);
    ifc.cpu_halt = 1'b0;
    tick(2);
    check("idle_after_halt", int'(ifc.run_mode), 0);
    check("step_count_after_halt", int'(ifc.step_count), model_count);

    // View wrap, then advance to view 3.
    for (int v = 0; v < NV + int'($urandom_range(0, 5)); v++) begin
      expect_view();
      press(B_VIEW, $urandom_range(D, D + 3));
    end
    while (model_view != 3) begin
      expect_view();
      press(B_VIEW, D + 1);
    end
    check("view_sel_before_cpu_reset", int'(ifc.view_sel), 3);

    // Clear the count, run five pulses, then reset the CPU from RUN.
    press(B_RST, D + 2);
    model_count = 0;
    check("step_count_cleared", int'(ifc.step_count), 0);
    check("cpu_rst_released", int'(ifc.cpu_rst), 0);
    set_btn(B_RUN, 1'b1);
    tick(LAT + 1);
    check("run_mode_entry_3", int'(ifc.run_mode), 1);
    set_btn(B_RUN, 1'b0);
    expect_pulses(5);
    tick(9);
    set_btn(B_RST, 1'b1);
    tick(LAT);
    check("step_count_five", int'(ifc.step_count), 5);
    tick(1);
    model_count = 0;
    check("cpu_reset_cpu_rst",    int'(ifc.cpu_rst), 1);
    check("cpu_reset_run_mode",   int'(ifc.run_mode), 0);
    check("cpu_reset_step_count", int'(ifc.step_count), 0);
    check("cpu_reset_view_sel",   int'(ifc.view_sel), 3);
    tick(3);
    check("cpu_rst_held", int'(ifc.cpu_rst), 1);
    set_btn(B_RST, 1'b0);
    tick(LAT);
    check("cpu_rst_until_release_seen", int'(ifc.cpu_rst), 1);
    tick(1);
    check("idle_after_cpu_reset", int'(ifc.cpu_rst), 0);
    tick(3);

    // Reset and step events in the same cycle: reset wins, no pulse.
    expect_pulses(1);
    press(B_STEP, D + 1);
    check("step_before_priority", int'(ifc.step_count), 1);
    set_btn(B_RST, 1'b1);
    set_btn(B_STEP, 1'b1);
    tick(LAT + 1);
    model_count = 0;
    check("priority_cpu_rst",    int'(ifc.cpu_rst), 1);
    check("priority_clk_en",     int'(ifc.cpu_clk_en), 0);
    check("priority_step_count", int'(ifc.step_count), 0);
    set_btn(B_RST, 1'b0);
    set_btn(B_STEP, 1'b0);
    tick(D + 6);
    check("priority_back_to_idle", int'(ifc.cpu_rst), 0);

    // Preload the counter to its maximum and step across the wrap.
    force dut.r_step_count = 16'hFFFF;
    #1;
    release dut.r_step_count;
    model_count = 65535;
    tick(1);
    check("preload_step_count", int'(ifc.step_count), 65535);
    expect_pulses(1);
    press(B_STEP, D + 2);
    check("step_count_wrap", int'(ifc.step_count), 0);

    tick(5);
    check("pending_pulses", exp_cnt.size(), 0);
    check("pending_views", exp_view.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_step_ctrl.md
BOARD_STEP_CTRL -- requirements
Module: board_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter RUN_DIV, default 50000000: clk cycles per CPU step in run mode (>=2).
REQ-003 SHALL have parameter NUM_VIEWS, default 7: number of display views (2..8).
REQ-004 SHALL have port clk  in  1  board clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn_rst  in  1  raw asynchronous button, CPU reset request.
REQ-007 SHALL have port btn_step  in  1  raw asynchronous button, single step.
REQ-008 SHALL have port btn_run  in  1  raw asynchronous button, run/stop toggle.
REQ-009 SHALL have port btn_view  in  1  raw asynchronous button, advance display view.
REQ-010 SHALL have port cpu_halt  in  1  synchronous halt request from the CPU.
REQ-011 SHALL have port cpu_clk_en  out  1  one-cycle enable; the CPU advances one clock per pulse.
REQ-012 SHALL have port cpu_rst  out  1  active-high CPU reset.
REQ-013 SHALL have port run_mode  out  1  high while in RUN.
REQ-014 SHALL have port view_sel  out  3  display view index.
REQ-015 SHALL have port step_count  out  16  CPU steps issued since the last CPU reset.

Function
REQ-016 SHALL pass each btn_* through a two-flop synchronizer.
REQ-017 SHALL debounce each synchronized button:
- the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles;
- any bounce restarts the count.
REQ-018 SHALL generate a one-cycle registered event on each debounced 0->1 edge; 1->0 edges produce no event.
REQ-019 SHALL implement FSM states IDLE, STEP, RUN, RESET, all outputs registered.
REQ-020 IDLE: step event -> STEP; run event -> RUN; otherwise stay.
REQ-021 STEP lasts exactly one cycle:
- cpu_clk_en=1 in that cycle;
- step_count increments;
- returns to IDLE.
REQ-022 RUN operation:
- run_mode=1;
- divider counts 0..RUN_DIV-1 and wraps;
- at terminal count, cpu_clk_en=1 for one cycle and step_count increments;
- step events are ignored.
REQ-023 RUN -> IDLE on a run event or on cpu_halt=1:
- the divider clears;
- no cpu_clk_en is issued in the exit cycle.
REQ-024 cpu_halt=1 in IDLE SHALL block run events, but SHALL NOT block step events.
REQ-025 Debounced btn_rst high SHALL force RESET from any state:
- cpu_rst=1, cpu_clk_en=0, run_mode=0;
- step_count=0 and divider=0;
- the FSM stays in RESET while btn_rst is high, then goes to IDLE on the next cycle.
REQ-026 Simultaneous-event priority, highest first: reset, halt, run toggle, step.
REQ-027 step_count SHALL wrap 16'hFFFF -> 0 without a flag.
REQ-028 view_sel:
- increments on each view event;
- wraps NUM_VIEWS-1 -> 0;
- operates in every FSM state;
- is unaffected by btn_rst.
REQ-029 cpu_clk_en SHALL never be high on two consecutive cycles.
REQ-030 Latency: cpu_clk_en in STEP is asserted exactly 1 cycle after the step event pulse.

Reset
REQ-031 rst low SHALL asynchronously clear all of the following:
- FSM to IDLE, synchronizers, debounced levels, debounce counters, divider;
- cpu_clk_en=0, run_mode=0, view_sel=0, step_count=0;
- cpu_rst=1 while rst is low, cpu_rst=0 on the first clk edge after rst deasserts.
REQ-032 Debounced levels SHALL reset to 0, so a button held through rst release produces one event after DEBOUNCE_CYCLES.

Verification
Parameters for all scenarios: DEBOUNCE_CYCLES=4, RUN_DIV=3, NUM_VIEWS=7.
REQ-033 Reset and step: rst low -> all outputs 0 except cpu_rst=1; btn_step high for 10 cycles -> exactly one cpu_clk_en pulse, step_count=1; a 2-cycle btn_step glitch -> no pulse.
REQ-034 Run mode: btn_run press -> run_mode=1, one cpu_clk_en every 3 cycles, step_count=3 after 9 RUN cycles; second btn_run press -> run_mode=0 and pulses stop.
REQ-035 Halt: cpu_halt=1 in RUN -> IDLE next cycle, run_mode=0, no further pulses; btn_run press while cpu_halt=1 -> stays IDLE.
REQ-036 View wrap: 7 btn_view presses -> view_sel sequence 1,2,3,4,5,6,0.
REQ-037 CPU reset: btn_rst pressed in RUN with step_count=5 and view_sel=3 -> cpu_rst=1, run_mode=0, step_count=0, view_sel=3; btn_rst release -> IDLE.
REQ-038 Priority: btn_rst and btn_step events in the same cycle -> RESET with no cpu_clk_en; step_count 16'hFFFF plus one step -> step_count=0.
